// File: rtl/display_input_ctrl.sv
// Front end for the 8-digit seven-segment stage: synchronises and debounces two buttons,
// and turns them into one-cycle write strobes, auto-increment writes and a sequenced clear.

module display_input_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The level only moves after the synchronised input has disagreed with it for
    // DEBOUNCE_CYCLES counted cycles plus the cycle that commits the change.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values;
            // this is what makes the two-flop synchroniser a real two-stage chain.
            sync1_q      <= raw_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign rise_o = level_q & ~level_prev_q;

endmodule

module display_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_write_raw,
    input  logic       btn_clear_raw,
    input  logic [3:0] sw_num,
    input  logic [2:0] sw_sel,
    input  logic       auto_inc,
    output logic       write,
    output logic [3:0] num,
    output logic [2:0] sel,
    output logic       busy,
    output logic [2:0] ptr
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] clr_idx_q;
    logic [2:0] clr_idx_d;
    logic       write_q;
    logic       write_d;
    logic [3:0] num_q;
    logic [3:0] num_d;
    logic [2:0] sel_q;
    logic [2:0] sel_d;
    logic       busy_q;
    logic       busy_d;
    logic [2:0] ptr_q;
    logic [2:0] ptr_d;
    logic       wr_evt;
    logic       clr_evt;

    display_input_ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_write (
        .clk   (clk),
        .reset (reset),
        .raw_i (btn_write_raw),
        .rise_o(wr_evt)
    );

    display_input_ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_clear (
        .clk   (clk),
        .reset (reset),
        .raw_i (btn_clear_raw),
        .rise_o(clr_evt)
    );

    // The first clear write (digit 0) is issued on the IDLE->CLEAR edge, so busy and the
    // eight clear strobes line up exactly; clr_idx then names the next digit to blank.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        write_d   = 1'b0;
        num_d     = num_q;
        sel_d     = sel_q;
        busy_d    = 1'b0;
        ptr_d     = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_evt) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = 3'd1;
                    write_d   = 1'b1;
                    num_d     = 4'd0;
                    sel_d     = 3'd0;
                    busy_d    = 1'b1;
                end else if (wr_evt) begin
                    write_d = 1'b1;
                    num_d   = sw_num;
                    if (auto_inc) begin
                        sel_d = ptr_q;
                        ptr_d = ptr_q + 3'd1;
                    end else begin
                        sel_d = sw_sel;
                    end
                end
            end
            ST_CLEAR: begin
                // Button events in this state are single-cycle and simply fall away.
                write_d   = 1'b1;
                num_d     = 4'd0;
                sel_d     = clr_idx_q;
                busy_d    = 1'b1;
                clr_idx_d = clr_idx_q + 3'd1;
                if (clr_idx_q == 3'd7) begin
                    state_d = ST_IDLE;
                    ptr_d   = 3'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            clr_idx_q <= 3'd0;
            write_q   <= 1'b0;
            num_q     <= 4'd0;
            sel_q     <= 3'd0;
            busy_q    <= 1'b0;
            ptr_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            write_q   <= write_d;
            num_q     <= num_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
        end
    end

    assign write = write_q;
    assign num   = num_q;
    assign sel   = sel_q;
    assign busy  = busy_q;
    assign ptr   = ptr_q;

endmodule

// File: tb/tb_display_input_ctrl.sv
// Self-checking bench for display_input_ctrl with DEBOUNCE_CYCLES=4: directed steps plus
// randomized presses, compared against a press-level model of pointer and write behaviour.

module tb_display_input_ctrl;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_write_raw;
    logic       btn_clear_raw;
    logic [3:0] sw_num;
    logic [2:0] sw_sel;
    logic       auto_inc;
    logic       write;
    logic [3:0] num;
    logic [2:0] sel;
    logic       busy;
    logic [2:0] ptr;

    display_input_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_write_raw(btn_write_raw),
        .btn_clear_raw(btn_clear_raw),
        .sw_num       (sw_num),
        .sw_sel       (sw_sel),
        .auto_inc     (auto_inc),
        .write        (write),
        .num          (num),
        .sel          (sel),
        .busy         (busy),
        .ptr          (ptr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int         at;
        logic [2:0] sel;
        logic [3:0] num;
        logic       busy;
    } wr_t;

    wr_t obs[512];
    int  obs_n  = 0;
    int  busy_n = 0;

    always @(negedge clk) begin
        if (write === 1'b1 && obs_n < 512) begin
            obs[obs_n].at   = cyc;
            obs[obs_n].sel  = sel;
            obs[obs_n].num  = num;
            obs[obs_n].busy = busy;
            obs_n = obs_n + 1;
        end
        if (busy === 1'b1) busy_n = busy_n + 1;
    end

    int checks   = 0;
    int failures = 0;
    int rd       = 0;
    int m_ptr    = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected)
        else begin
            failures = failures + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input string tag, input int at, input int e_sel, input int e_num,
                                input int e_busy);
        check({tag, "_present"}, 32'(obs_n > rd), 32'(1));
        if (obs_n > rd) begin
            check({tag, "_cycle"}, 32'(obs[rd].at), 32'(at));
            check({tag, "_sel"},   32'(obs[rd].sel), 32'(e_sel));
            check({tag, "_num"},   32'(obs[rd].num), 32'(e_num));
            check({tag, "_busy"},  32'(obs[rd].busy), 32'(e_busy));
            rd = rd + 1;
        end
    endtask

    task automatic expect_none(input string tag);
        check(tag, 32'(obs_n - rd), 32'(0));
        rd = obs_n;
    endtask

    task automatic expect_zero_outputs(input string tag);
        check({tag, "_write"}, 32'(write), 32'(0));
        check({tag, "_num"},   32'(num),   32'(0));
        check({tag, "_sel"},   32'(sel),   32'(0));
        check({tag, "_busy"},  32'(busy),  32'(0));
        check({tag, "_ptr"},   32'(ptr),   32'(0));
    endtask

    // Called at posedge+1; start is the edge that first samples the pressed level.
    task automatic press(input bit do_w, input bit do_c, input int hold, output int start);
        btn_write_raw = do_w;
        btn_clear_raw = do_c;
        start = cyc + 1;
        tick(hold);
        btn_write_raw = 1'b0;
        btn_clear_raw = 1'b0;
        tick(12);
    endtask

    task automatic expect_clear(input string tag, input int start);
        for (int k = 0; k < 8; k++) expect_write(tag, start + LAT + k, k, 0, 1);
    endtask

    initial begin
        int s;
        int b0;
        int e_sel;
        logic [3:0] last_num;

        // Reset held with arbitrary inputs.
        reset         = 1'b0;
        btn_write_raw = 1'($urandom_range(0, 1));
        btn_clear_raw = 1'($urandom_range(0, 1));
        sw_num        = 4'($urandom_range(0, 15));
        sw_sel        = 3'($urandom_range(0, 7));
        auto_inc      = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) begin
            tick(1);
            btn_write_raw = ~btn_write_raw;
            btn_clear_raw = 1'($urandom_range(0, 1));
        end
        expect_zero_outputs("in_reset");
        btn_write_raw = 1'b0;
        btn_clear_raw = 1'b0;
        reset         = 1'b1;
        tick(20);
        expect_none("reset_idle_no_write");
        expect_zero_outputs("after_reset");

        // Bounce rejection: toggle every two cycles for thirty cycles.
        for (int i = 0; i < 15; i++) begin
            btn_write_raw = ~btn_write_raw;
            tick(2);
        end
        btn_write_raw = 1'b0;
        tick(15);
        expect_none("bounce_no_write");

        // Clean press with explicit select.
        auto_inc = 1'b0;
        sw_sel   = 3'd5;
        sw_num   = 4'hA;
        press(1'b1, 1'b0, 20, s);
        expect_write("clean", s + LAT, 5, 'hA, 0);
        tick(10);
        expect_none("clean_release");
        check("clean_ptr", 32'(ptr), 32'(m_ptr));

        // Auto-increment across the 7->0 wrap.
        auto_inc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sw_num = 4'(i);
            press(1'b1, 1'b0, 8, s);
            expect_write("wrap", s + LAT, m_ptr, i, 0);
            m_ptr = (m_ptr + 1) % 8;
        end
        check("wrap_ptr_end", 32'(ptr), 32'(2));

        // Clear sequence.
        b0 = busy_n;
        press(1'b0, 1'b1, 10, s);
        expect_clear("clear", s);
        tick(5);
        expect_none("clear_tail");
        check("clear_busy_cycles", 32'(busy_n - b0), 32'(8));
        m_ptr = 0;
        check("clear_ptr", 32'(ptr), 32'(m_ptr));

        // Simultaneous write and clear: clear wins.
        sw_num = 4'h3;
        press(1'b1, 1'b0, 8, s);
        expect_write("pre_collide", s + LAT, m_ptr, 3, 0);
        m_ptr = (m_ptr + 1) % 8;
        press(1'b1, 1'b1, 10, s);
        expect_clear("collide", s);
        tick(10);
        expect_none("collide_no_write");
        m_ptr = 0;
        check("collide_ptr", 32'(ptr), 32'(m_ptr));

        // Write press completing during CLEAR is dropped.
        btn_clear_raw = 1'b1;
        s = cyc + 1;
        tick(2);
        btn_write_raw = 1'b1;
        tick(10);
        btn_clear_raw = 1'b0;
        tick(2);
        btn_write_raw = 1'b0;
        tick(15);
        expect_clear("clear_drop", s);
        expect_none("clear_drop_no_write");

        // Reset asserted on the fourth clear write.
        btn_clear_raw = 1'b1;
        s = cyc + 1;
        tick(LAT + 4);
        check("abort_4th_write", 32'(write), 32'(1));
        check("abort_4th_sel", 32'(sel), 32'(3));
        reset         = 1'b0;
        btn_clear_raw = 1'b0;
        #1;
        expect_zero_outputs("abort_reset");
        for (int k = 0; k < 3; k++) expect_write("abort_pre", s + LAT + k, k, 0, 1);
        tick(2);
        reset = 1'b1;
        tick(20);
        expect_none("abort_no_write");
        m_ptr = 0;

        // Randomized glitches and presses against the model.
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 1) btn_write_raw = 1'b1;
            else                           btn_clear_raw = 1'b1;
            tick($urandom_range(1, DB - 1));
            btn_write_raw = 1'b0;
            btn_clear_raw = 1'b0;
            tick(12);
            expect_none("rand_glitch");

            auto_inc = 1'($urandom_range(0, 1));
            sw_num   = 4'($urandom_range(0, 15));
            sw_sel   = 3'($urandom_range(0, 7));
            last_num = sw_num;
            e_sel    = auto_inc ? m_ptr : int'(sw_sel);
            press(1'b1, 1'b0, $urandom_range(6, 12), s);
            expect_write("rand_press", s + LAT, e_sel, int'(last_num), 0);
            if (auto_inc) m_ptr = (m_ptr + 1) % 8;
            check("rand_ptr", 32'(ptr), 32'(m_ptr));
            sw_num = ~last_num;
            sw_sel = 3'($urandom_range(0, 7));
            tick(3);
            check("rand_num_hold", 32'(num), 32'(last_num));
            check("rand_sel_hold", 32'(sel), 32'(e_sel));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_input_ctrl.md
Name: display_input_ctrl

Overview:
- Upstream front end for the 8-digit seven-segment display stage.
- Converts raw board switches and two push-buttons into clean display-stage inputs: one-cycle `write` pulses, a 4-bit `num` and a 3-bit `sel`.
- Synchronises and debounces both buttons, and optionally auto-advances the digit pointer.
- Supports a sequenced clear of all eight digits.

Parameters:
- DEBOUNCE_CYCLES, 65536: number of consecutive stable clk cycles required before a debounced button level changes. Legal range is >= 2; benches use 4.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of each debounce counter. Derived; not overridden.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- btn_write_raw  input  1  raw write push-button, asynchronous, bouncing.
- btn_clear_raw  input  1  raw clear push-button, asynchronous, bouncing.
- sw_num  input  4  hex value to store.
- sw_sel  input  3  digit index used when auto_inc=0.
- auto_inc  input  1  1 = use internal pointer and post-increment it; 0 = use sw_sel.
- write  output  1  one-cycle write strobe to the display stage.
- num  output  4  data accompanying write.
- sel  output  3  digit index accompanying write.
- busy  output  1  high while the clear sequence runs.
- ptr  output  3  current auto-increment pointer, for debug LEDs.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: write=0, num=0, sel=0, busy=0, ptr=0.
  - Internal state: synchronisers=0, debounced levels=0, counters=0, FSM=IDLE.
  - Release of reset is synchronous to clk. Reset mid-clear aborts the clear immediately; no further writes are issued.
- Synchronisers: each raw button passes through a 2-flop synchroniser. Switches and auto_inc are sampled directly; they are quasi-static.
- Debounce, per button:
  - The counter increments while sync value != debounced level and clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the sync value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Edge detect: an event is a 0->1 transition of the debounced level, one cycle wide. Release (1->0) produces no event.
- Latency: a clean press held steady produces write=1 exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples raw=1. This is 2 synchroniser stages, DEBOUNCE_CYCLES filter cycles, and 1 registered output.
- All outputs are registered. num and sel change only in the cycle write=1, and otherwise hold their last values.
- FSM states: IDLE, CLEAR.
- IDLE:
  - Clear event: go to CLEAR with clr_idx=0 and busy=1 on the next cycle.
  - Write event and auto_inc=1: write=1, num=sw_num, sel=ptr, and ptr <= ptr+1 (mod 8, so 7 wraps to 0).
  - Write event and auto_inc=0: write=1, num=sw_num, sel=sw_sel, and ptr is unchanged.
  - Clear and write events in the same cycle: clear wins and the write event is discarded.
- CLEAR:
  - Runs for eight consecutive cycles. Each cycle gives write=1, num=0, sel=clr_idx, and clr_idx increments.
  - After sel=7 is written: return to IDLE, busy=0, ptr=0.
  - busy=1 on exactly the 8 write cycles.
  - Write and clear events arriving during CLEAR are dropped, not queued.
- Toggling auto_inc is honoured on the next event only. ptr is not modified by the toggle.
- At most one write per cycle. In IDLE there is at least one write=0 cycle between button-initiated writes, which the debounce guarantees.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold reset=0 with arbitrary inputs, then release -> all outputs 0 and no write pulse for 20 cycles with buttons idle.
- Bounce rejection: btn_write_raw toggles every 2 cycles for 30 cycles, then settles at 0 -> write never asserts.
- Clean press: auto_inc=0, sw_sel=5, sw_num=A, press held for 20 cycles -> exactly one write pulse 7 edges after the sampling edge with sel=5 and num=A. Release -> no pulse.
- Auto-increment wrap: auto_inc=1, ten presses with sw_num=0..9 -> sel sequence 0,1,…,7,0,1, ptr ends at 2, and num matches each press.
- Clear: after the wrap test, press clear -> eight consecutive pulses with sel=0..7 and num=0, busy high for exactly those 8 cycles, then ptr=0.
- Collisions: write and clear debounced rises in the same cycle -> only the clear sequence occurs. A write press completing during CLEAR -> no write after the sequence. Assert reset at the 4th clear write -> write=0 immediately and outputs return to reset values.
